memory_cycle_lsu: RTL

MEMORY_CYCLE_LSU -- requirements
Module: memory_cycle_lsu

---
 rtl/riscv_pkg.sv | 54 +++++
 rtl/memory_cycle_lsu_if.sv | 37 +++
 rtl/memory_cycle_lsu_dmem.sv | 25 ++
 rtl/memory_cycle_lsu.sv | 130 +++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the memory stage: funct3 access codes, LSU FSM states,
// write-back register layout and load-lane extraction.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {ST_IDLE, ST_BUSY} lsu_state_e;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} acc_size_e;

  typedef struct packed {
    logic        reg_write;
    logic        result_src;
    logic        misalign;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
    logic [31:0] alu_result;
    logic [31:0] read_data;
  } wb_t;

  // Unlisted funct3 codes fall back to a full-word access.
  function automatic acc_size_e f3_size(input logic [2:0] f3);
    acc_size_e s;
    case (f3)
      F3_B, F3_BU: s = SZ_B;
      F3_H, F3_HU: s = SZ_H;
      default:     s = SZ_W;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                               input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'h0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/memory_cycle_lsu_if.sv
// M-stage request / W-stage result bundle between the pipeline and the LSU.
interface memory_cycle_lsu_if #(
  parameter int XLEN = 32
);
  logic            RegWriteM;
  logic            MemReadM;
  logic            MemWriteM;
  logic            ResultSrcM;
  logic [2:0]      Funct3M;
  logic [4:0]      RD_M;
  logic [XLEN-1:0] PCPlus4M;
  logic [XLEN-1:0] ALU_ResultM;
  logic [XLEN-1:0] WriteDataM;

  logic            StallM;
  logic            RegWriteW;
  logic            ResultSrcW;
  logic            MisalignW;
  logic [4:0]      RD_W;
  logic [XLEN-1:0] PCPlus4W;
  logic [XLEN-1:0] ALU_ResultW;
  logic [XLEN-1:0] ReadDataW;

  modport master (
    output RegWriteM, MemReadM, MemWriteM, ResultSrcM, Funct3M, RD_M,
           PCPlus4M, ALU_ResultM, WriteDataM,
    input  StallM, RegWriteW, ResultSrcW, MisalignW, RD_W,
           PCPlus4W, ALU_ResultW, ReadDataW
  );

  modport slave (
    input  RegWriteM, MemReadM, MemWriteM, ResultSrcM, Funct3M, RD_M,
           PCPlus4M, ALU_ResultM, WriteDataM,
    output StallM, RegWriteW, ResultSrcW, MisalignW, RD_W,
           PCPlus4W, ALU_ResultW, ReadDataW
  );
endinterface

// File: rtl/memory_cycle_lsu_dmem.sv
// Word-organised data memory: byte-enabled synchronous write, combinational read.
module lsu_dmem #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [3:0]               be_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/memory_cycle_lsu.sv
// Memory-stage load/store unit with a fixed-latency wait-state FSM and the
// M/W pipeline register.
module memory_cycle_lsu
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024,
  parameter int WAIT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  memory_cycle_lsu_if.slave  bus
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [2:0] WAIT_LD = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

  lsu_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  acc_size_e   size;
  logic [1:0]  lane;
  logic        mem_op, misalign, pending, stall, complete, mem_we;
  logic [3:0]  be;
  logic [31:0] wdata, rword, load_data;
  wb_t         w_q, w_d;

  always_comb begin
    lane     = bus.ALU_ResultM[1:0];
    size     = f3_size(bus.Funct3M);
    mem_op   = bus.MemReadM | bus.MemWriteM;
    misalign = mem_op & (((size == SZ_H) & lane[0]) | ((size == SZ_W) & (lane != 2'b00)));
    pending  = mem_op & ~misalign;
    case (size)
      SZ_B: begin
        be    = 4'b0001 << lane;
        wdata = {4{bus.WriteDataM[7:0]}};
      end
      SZ_H: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.WriteDataM[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = bus.WriteDataM[31:0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pending && (WAIT > 0)) begin
          state_d = ST_BUSY;
          cnt_d   = WAIT_LD;
        end
      end
      ST_BUSY: begin
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        else               state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall and commit are gated by reset so an access held across reset never commits.
  always_comb begin
    stall    = 1'b0;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall    = rst & pending & (WAIT > 0);
        complete = rst & pending & (WAIT == 0);
      end
      ST_BUSY: begin
        stall    = rst & (cnt_q != 3'd0);
        complete = rst & (cnt_q == 3'd0);
      end
      default: ;
    endcase
    mem_we = complete & bus.MemWriteM;
  end

  lsu_dmem #(.DEPTH(DEPTH)) u_dmem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .be_i    (be),
    .addr_i  (bus.ALU_ResultM[AW+1:2]),
    .wdata_i (wdata),
    .rdata_o (rword)
  );

  assign load_data = load_extract(bus.Funct3M, lane, rword);

  always_comb begin
    w_d.reg_write  = bus.RegWriteM & ~misalign & ~stall;
    w_d.misalign   = misalign & ~stall;
    w_d.result_src = bus.ResultSrcM;
    w_d.rd         = bus.RD_M;
    w_d.pc_plus4   = bus.PCPlus4M[31:0];
    w_d.alu_result = bus.ALU_ResultM[31:0];
    w_d.read_data  = load_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) w_q <= '0;
    else      w_q <= w_d;
  end

  assign bus.StallM      = stall;
  assign bus.RegWriteW   = w_q.reg_write;
  assign bus.ResultSrcW  = w_q.result_src;
  assign bus.MisalignW   = w_q.misalign;
  assign bus.RD_W        = w_q.rd;
  assign bus.PCPlus4W    = w_q.pc_plus4;
  assign bus.ALU_ResultW = w_q.alu_result;
  assign bus.ReadDataW   = w_q.read_data;

endmodule
